mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-requester arbiter that shares the single 128-bit line memory port between the L1 instruction cache and the L1 data cache.
- Sits between both caches' mem_* interfaces and the memory model.
- Serialises one line transaction at a time and holds the grant until the transaction completes.
- Routes mem_ready back only to the granted cache; mem_rdata is broadcast to both caches.

Parameters:
ADDR_W, 30, line-address width (word address, bits [29:0])
DATA_W, 128, line width in bits

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
i_mem_read  input  1  I-cache line read request (level, held until i_mem_ready)
i_mem_addr  input  ADDR_W  I-cache request address
i_mem_rdata  output  DATA_W  read data to I-cache (= mem_rdata)
i_mem_ready  output  1  completion pulse to I-cache
d_mem_read  input  1  D-cache line read request
d_mem_write  input  1  D-cache line write-back request
d_mem_addr  input  ADDR_W  D-cache request address
d_mem_wdata  input  DATA_W  D-cache write-back data
d_mem_rdata  output  DATA_W  read data to D-cache (= mem_rdata)
d_mem_ready  output  1  completion pulse to D-cache
mem_read  output  1  memory read strobe (registered)
mem_write  output  1  memory write strobe (registered)
mem_addr  output  ADDR_W  memory address (registered)
mem_wdata  output  DATA_W  memory write data (registered)
mem_rdata  input  DATA_W  memory read data
mem_ready  input  1  memory completion, one-cycle pulse

Behaviour:
- Interface decision: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset (asserted at any time, including mid-transaction): state=IDLE; mem_read, mem_write, mem_addr, mem_wdata all 0; last_grant=D. Any in-flight transaction is abandoned; both caches are reset alongside the arbiter.
- States: IDLE, BUSY_I, BUSY_D, DONE.
- IDLE:
  - Sample requests. d_req = d_mem_read|d_mem_write; i_req = i_mem_read.
  - No request: stay in IDLE.
  - Only i_req: go to BUSY_I. Register mem_read=1, mem_addr=i_mem_addr.
  - Only d_req: go to BUSY_D. Register mem_addr=d_mem_addr and mem_wdata=d_mem_wdata.
    - If d_mem_write=1: mem_write=1, mem_read=0. Write wins if both strobes are high.
    - Else: mem_read=1.
  - Both i_req and d_req: D wins (fixed priority; see optional feature).
  - Latency: request present in IDLE at cycle N gives strobe visible at cycle N+1.
- BUSY_x:
  - Strobes, address and data are held constant.
  - Requester inputs are ignored, even if the requester drops its request; memory transactions cannot be aborted.
  - When mem_ready=1: x_mem_ready = 1 combinationally in the same cycle. The non-granted ready stays 0.
  - Next cycle: mem_read=mem_write=0, state goes to DONE, last_grant=x.
- DONE:
  - One-cycle bubble so the completed cache can deassert its registered request. No grant is issued.
  - Next state: IDLE.
  - Minimum spacing between transactions is therefore 2 idle cycles after ready.
- Ready routing: mem_ready arriving in IDLE or DONE is ignored and is not forwarded.
- i_mem_rdata and d_mem_rdata both equal mem_rdata at all times. Each cache qualifies the data with its own ready.
- A D-cache write-back followed by a refill is two separate transactions. The I-cache may be granted between them if RR is enabled.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - Round-robin on simultaneous requests in IDLE: grant the requester != last_grant.
  - last_grant is a 1-bit register, reset value D, updated on each completion.
- Undefined:
  - Fixed priority, D-cache always wins. last_grant register is not instantiated.
  - The I-cache may starve under continuous D traffic; this is accepted for the baseline.

Test Plan:
- Reset: rst_n=0 asynchronously mid-BUSY_D with mem_write=1 -> mem_write, mem_read, mem_addr drop to 0 without a clock edge; state IDLE after release.
- Single I read: i_mem_read=1, addr=0x10, memory returns 0xDEADBEEF_..._01 after 3 cycles -> mem_read=1 and mem_addr=0x10 one cycle after the request; i_mem_ready pulses once with that data; d_mem_ready stays 0.
- D write-back: d_mem_write=1, d_mem_read=1, addr=0x2A4, wdata=0xA5A5... -> mem_write=1, mem_read=0, mem_wdata=0xA5A5...; d_mem_ready on mem_ready; then DONE, then IDLE.
- Simultaneous requests, RR undefined: i and d both request at addr 0x8 and 0x40 -> D served first, then I granted 2 cycles after D's ready.
- Simultaneous requests, MEM_ARB_RR_EN defined, last_grant=D -> I served first; with both held, grants alternate I, D, I, D.
- Requester drop: deassert i_mem_read during BUSY_I -> mem_read held until mem_ready; i_mem_ready still pulses; no spurious second grant.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 128-bit line memory port between the L1 I-cache and D-cache.
// Optional feature macro MEM_ARB_RR_EN: round-robin on simultaneous requests (default: D-cache always wins).
module mem_arbiter #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  // state   | meaning
  // IDLE    | sample requests, issue grant
  // BUSY_I  | I-cache line transaction in flight
  // BUSY_D  | D-cache line transaction in flight
  // DONE    | one-cycle bubble so the served cache can drop its request
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              w_read_nxt;
  logic              w_write_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_wdata_nxt;

  logic w_i_req;
  logic w_d_req;
  logic w_d_wins;
  logic w_grant_d;
  logic w_grant_i;
  logic w_i_done;
  logic w_d_done;

  assign w_i_req   = i_mem_read;
  assign w_d_req   = d_mem_read | d_mem_write;
  assign w_grant_d = w_d_req & (~w_i_req | w_d_wins);
  assign w_grant_i = w_i_req & ~w_grant_d;

  // mem_ready outside a BUSY state is never forwarded
  assign w_i_done = (r_state == ST_BUSY_I) & mem_ready;
  assign w_d_done = (r_state == ST_BUSY_D) & mem_ready;

`ifdef MEM_ARB_RR_EN
  logic r_last_d;
  logic w_last_d_nxt;

  always_comb begin
    w_last_d_nxt = r_last_d;
    if (w_i_done) w_last_d_nxt = 1'b0;
    if (w_d_done) w_last_d_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_last_d <= 1'b1;
    else        r_last_d <= w_last_d_nxt;
  end

  // on a tie the requester that was not served last goes next
  assign w_d_wins = ~r_last_d;
`else
  assign w_d_wins = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_read_nxt  = r_mem_read;
    w_write_nxt = r_mem_write;
    w_addr_nxt  = r_mem_addr;
    w_wdata_nxt = r_mem_wdata;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = ST_BUSY_D;
          w_addr_nxt  = d_mem_addr;
          w_wdata_nxt = d_mem_wdata;
          w_write_nxt = d_mem_write;
          w_read_nxt  = ~d_mem_write;
        end else if (w_grant_i) begin
          w_state_nxt = ST_BUSY_I;
          w_addr_nxt  = i_mem_addr;
          w_read_nxt  = 1'b1;
          w_write_nxt = 1'b0;
        end
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (mem_ready) begin
          w_state_nxt = ST_DONE;
          w_read_nxt  = 1'b0;
          w_write_nxt = 1'b0;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_read  <= w_read_nxt;
      r_mem_write <= w_write_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
    end
  end

  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign i_mem_ready = w_i_done;
  assign d_mem_ready = w_d_done;
  assign i_mem_rdata = mem_rdata;
  assign d_mem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: transaction-level reference model plus directed and random scenarios.
module tb_mem_arbiter;
  localparam int AW = 30;
  localparam int DW = 128;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_mem_read = 1'b0;
  logic [AW-1:0] i_mem_addr = '0;
  logic [DW-1:0] i_mem_rdata;
  logic          i_mem_ready;
  logic          d_mem_read = 1'b0;
  logic          d_mem_write = 1'b0;
  logic [AW-1:0] d_mem_addr = '0;
  logic [DW-1:0] d_mem_wdata = '0;
  logic [DW-1:0] d_mem_rdata;
  logic          d_mem_ready;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_read(i_mem_read), .i_mem_addr(i_mem_addr),
    .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
    .d_mem_read(d_mem_read), .d_mem_write(d_mem_write),
    .d_mem_addr(d_mem_addr), .d_mem_wdata(d_mem_wdata),
    .d_mem_rdata(d_mem_rdata), .d_mem_ready(d_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model: the transaction currently owning the memory port
  logic          cur_v = 1'b0;
  logic          cur_d = 1'b0;
  logic          cur_rd = 1'b0;
  logic          cur_wr = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] exp_wdata = '0;
  int            cur_start = 0;
  int            cur_lat = 0;
  int            idle_from = 0;
  logic          last_d = 1'b1;
  logic          prev_idle = 1'b1;
  logic          prev_strobe = 1'b0;
  logic          done_i = 1'b0;
  logic          done_d = 1'b0;
  int            last_ready_cyc = 0;
  int            force_lat = -1;
  logic          spurious_en = 1'b0;
  logic          use_fixed = 1'b0;
  logic [DW-1:0] fixed_rdata = '0;
  logic          dut_log[$];
  int            rise_q[$];

  function automatic logic [DW-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    cur_v = 1'b0; last_d = 1'b1; exp_wdata = '0; prev_idle = 1'b1;
    idle_from = 0; prev_strobe = 1'b0; done_i = 1'b0; done_d = 1'b0;
  endtask

  task automatic clear_inputs();
    i_mem_read = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  // One clock: decide grants from the request lines the DUT just sampled, check strobes,
  // play the memory, then check ready routing.
  task automatic step();
    logic pi, pdr, pdw, pick_d, busy_now, exp_ir, exp_dr, strobe;
    @(negedge clk);
    cyc++;
    pi = i_mem_read; pdr = d_mem_read; pdw = d_mem_write;
    if (prev_idle && (pi || pdr || pdw)) begin
      if ((pdr || pdw) && pi) pick_d = RR ? ~last_d : 1'b1;
      else                    pick_d = pdr | pdw;
      cur_v = 1'b1; cur_d = pick_d;
      cur_wr = pick_d & pdw;
      cur_rd = ~cur_wr;
      cur_addr = pick_d ? d_mem_addr : i_mem_addr;
      if (pick_d) exp_wdata = d_mem_wdata;
      cur_start = cyc;
      cur_lat = (force_lat >= 0) ? force_lat : $urandom_range(0, 3);
    end
    strobe = mem_read | mem_write;
    if (strobe === 1'b1 && !prev_strobe) rise_q.push_back(cyc);
    prev_strobe = (strobe === 1'b1);
    checks++;
    if (cur_v) begin
      if (mem_read !== cur_rd || mem_write !== cur_wr || mem_addr !== cur_addr || mem_wdata !== exp_wdata) begin
        errors++;
        $display("FAIL strobe cyc=%0d got rd=%b wr=%b addr=%h wdata=%h expected rd=%b wr=%b addr=%h wdata=%h",
                 cyc, mem_read, mem_write, mem_addr, mem_wdata, cur_rd, cur_wr, cur_addr, exp_wdata);
      end
    end else if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL idle_strobe cyc=%0d got rd=%b wr=%b expected rd=0 wr=0", cyc, mem_read, mem_write);
    end
    if (cur_v && (cyc - cur_start) >= cur_lat) begin
      mem_ready = 1'b1;
      mem_rdata = use_fixed ? fixed_rdata : rnd128();
    end else begin
      mem_ready = spurious_en && ($urandom_range(0, 7) == 0);
      mem_rdata = rnd128();
    end
    #1;
    exp_ir = mem_ready & cur_v & ~cur_d;
    exp_dr = mem_ready & cur_v & cur_d;
    checks++;
    if (i_mem_ready !== exp_ir || d_mem_ready !== exp_dr || i_mem_rdata !== mem_rdata || d_mem_rdata !== mem_rdata) begin
      errors++;
      $display("FAIL ready_route cyc=%0d got i_rdy=%b d_rdy=%b expected i_rdy=%b d_rdy=%b rdata_ok=%b/%b",
               cyc, i_mem_ready, d_mem_ready, exp_ir, exp_dr, i_mem_rdata === mem_rdata, d_mem_rdata === mem_rdata);
    end
    if (i_mem_ready === 1'b1) dut_log.push_back(1'b0);
    if (d_mem_ready === 1'b1) dut_log.push_back(1'b1);
    busy_now = cur_v;
    done_i = 1'b0; done_d = 1'b0;
    if (cur_v && mem_ready) begin
      done_i = ~cur_d; done_d = cur_d; last_d = cur_d;
      cur_v = 1'b0; idle_from = cyc + 2; last_ready_cyc = cyc;
    end
    prev_idle = ~busy_now && (cyc >= idle_from);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_values got rd=%b wr=%b addr=%h wdata=%h expected all zero", mem_read, mem_write, mem_addr, mem_wdata);
    end
    apply_reset();
    step();
    d_mem_write = 1'b1; d_mem_addr = 30'h2A4; d_mem_wdata = rnd128(); force_lat = 20;
    step();
    step();
    checks++;
    if (mem_write !== 1'b1 || mem_addr !== 30'h2A4) begin
      errors++;
      $display("FAIL reset_setup got wr=%b addr=%h expected wr=1 addr=2a4", mem_write, mem_addr);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL async_reset got rd=%b wr=%b addr=%h wdata=%h expected all zero", mem_read, mem_write, mem_addr, mem_wdata);
    end
    force_lat = -1;
    apply_reset();
    repeat (2) step();
    checks++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got rd=%b wr=%b expected 0 0", mem_read, mem_write);
    end
  endtask

  task automatic test_single_i();
    int ni, nd;
    logic got;
    logic [DW-1:0] data;
    ni = 0; nd = 0; got = 1'b0; data = '0;
    force_lat = 3; use_fixed = 1'b1;
    fixed_rdata = 128'hDEADBEEF_0000_0000_0000_0000_0000_0001;
    i_mem_read = 1'b1; i_mem_addr = 30'h10;
    step();
    checks++;
    if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 30'h10) begin
      errors++;
      $display("FAIL single_i_strobe got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=10", mem_read, mem_write, mem_addr);
    end
    for (int n = 0; n < 8; n++) begin
      step();
      if (i_mem_ready === 1'b1) begin ni++; data = i_mem_rdata; end
      if (d_mem_ready === 1'b1) nd++;
      if (done_i) begin i_mem_read = 1'b0; got = 1'b1; end
    end
    checks++;
    if (!got || ni != 1 || nd != 0 || data !== fixed_rdata) begin
      errors++;
      $display("FAIL single_i_ready got done=%b i_pulses=%0d d_pulses=%0d data=%h expected 1 1 0 %h", got, ni, nd, data, fixed_rdata);
    end
    use_fixed = 1'b0; force_lat = -1;
  endtask

  task automatic test_d_writeback();
    logic got;
    int nd;
    got = 1'b0; nd = 0;
    d_mem_write = 1'b1; d_mem_read = 1'b1; d_mem_addr = 30'h2A4; d_mem_wdata = {16{8'hA5}};
    step();
    checks++;
    if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_wdata !== {16{8'hA5}}) begin
      errors++;
      $display("FAIL wb_strobe got rd=%b wr=%b wdata=%h expected rd=0 wr=1 wdata=a5..", mem_read, mem_write, mem_wdata);
    end
    if (done_d) begin got = 1'b1; nd++; end
    for (int n = 0; n < 10 && !got; n++) begin
      step();
      if (d_mem_ready === 1'b1) nd++;
      if (done_d) got = 1'b1;
    end
    d_mem_write = 1'b0; d_mem_read = 1'b0;
    checks++;
    if (!got || nd != 1) begin
      errors++;
      $display("FAIL wb_ready got done=%b d_pulses=%0d expected 1 1", got, nd);
    end
    step();
    step();
    checks++;
    if (mem_write !== 1'b0 || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL wb_done got rd=%b wr=%b expected 0 0", mem_read, mem_write);
    end
  endtask

  task automatic test_simultaneous();
    int first_ready, served;
    logic exp_first;
    apply_reset();
    dut_log.delete(); rise_q.delete();
    served = 0; first_ready = 0;
    i_mem_read = 1'b1; i_mem_addr = 30'h8;
    d_mem_read = 1'b1; d_mem_addr = 30'h40;
    for (int n = 0; n < 40 && served < 2; n++) begin
      step();
      if (done_i) begin i_mem_read = 1'b0; served++; end
      if (done_d) begin d_mem_read = 1'b0; served++; end
      if (served == 1 && first_ready == 0) first_ready = cyc;
    end
    exp_first = RR ? 1'b0 : 1'b1;
    checks++;
    if (dut_log.size() != 2 || rise_q.size() != 2) begin
      errors++;
      $display("FAIL simul_count got readies=%0d grants=%0d expected 2 2", dut_log.size(), rise_q.size());
    end else if (dut_log[0] !== exp_first || dut_log[1] !== ~exp_first || rise_q[1] != first_ready + 3) begin
      errors++;
      $display("FAIL simul_order got first_d=%b second_d=%b grant2=%0d expected first_d=%b second_d=%b grant2=%0d",
               dut_log[0], dut_log[1], rise_q[1], exp_first, ~exp_first, first_ready + 3);
    end
    repeat (2) step();
    dut_log.delete();
    i_mem_read = 1'b1; d_mem_read = 1'b1;
    for (int n = 0; n < 60 && dut_log.size() < 4; n++) step();
    i_mem_read = 1'b0; d_mem_read = 1'b0;
    checks++;
    if (dut_log.size() < 4) begin
      errors++;
      $display("FAIL hold_both_timeout got readies=%0d expected 4", dut_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (dut_log[k] !== (RR ? (k % 2 == 1) : 1'b1)) begin
          errors++;
          $display("FAIL hold_both_order k=%0d got d=%b expected d=%b", k, dut_log[k], RR ? (k % 2 == 1) : 1'b1);
        end
      end
    end
    repeat (6) step();
  endtask

  task automatic test_drop();
    logic got;
    int ni;
    got = 1'b0; ni = 0;
    rise_q.delete();
    force_lat = 4;
    i_mem_read = 1'b1; i_mem_addr = AW'($urandom());
    step();
    i_mem_read = 1'b0; i_mem_addr = AW'($urandom());
    for (int n = 0; n < 10 && !got; n++) begin
      step();
      if (!got && !done_i && mem_read !== 1'b1) begin
        errors++;
        $display("FAIL drop_hold cyc=%0d got rd=%b expected rd=1", cyc, mem_read);
      end
      if (i_mem_ready === 1'b1) ni++;
      if (done_i) got = 1'b1;
    end
    checks++;
    if (!got || ni != 1) begin
      errors++;
      $display("FAIL drop_ready got done=%b i_pulses=%0d expected 1 1", got, ni);
    end
    repeat (5) step();
    checks++;
    if (rise_q.size() != 1) begin
      errors++;
      $display("FAIL drop_regrant got grants=%0d expected 1", rise_q.size());
    end
    force_lat = -1;
  endtask

  task automatic test_random();
    logic i_wait, d_wait;
    int k;
    i_wait = 1'b0; d_wait = 1'b0;
    spurious_en = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      step();
      if (i_wait) begin
        if (done_i) begin i_wait = 1'b0; i_mem_read = 1'b0; end
        else if (cur_v && !cur_d && $urandom_range(0, 5) == 0) begin
          i_mem_read = 1'b0; i_mem_addr = AW'($urandom());
        end
      end else if ($urandom_range(0, 2) == 0) begin
        i_wait = 1'b1; i_mem_read = 1'b1; i_mem_addr = AW'($urandom());
      end
      if (d_wait) begin
        if (done_d) begin d_wait = 1'b0; d_mem_read = 1'b0; d_mem_write = 1'b0; end
        else if (cur_v && cur_d && $urandom_range(0, 5) == 0) begin
          d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_wdata = rnd128();
        end
      end else if ($urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, 2);
        d_wait = 1'b1; d_mem_read = (k != 1); d_mem_write = (k != 0);
        d_mem_addr = AW'($urandom()); d_mem_wdata = rnd128();
      end
    end
    clear_inputs();
    spurious_en = 1'b0;
    repeat (8) step();
  endtask

  initial begin
    test_reset();
    test_single_i();
    test_d_writeback();
    test_simultaneous();
    test_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
